// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } arb_src_t;

    localparam logic [2:0]  FUNCT3_WORD = 3'b010;
    localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with a last-winner flop that updates on every grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if_c,
    output logic gnt_d_c
);

    arb_src_t last_winner;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_d_c  = 1'b0;
        if (en) begin
            if (req_if && req_d) begin
                gnt_if_c = (last_winner == SRC_D);
                gnt_d_c  = (last_winner == SRC_IF);
            end else begin
                gnt_if_c = req_if;
                gnt_d_c  = req_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= SRC_D;
        end else if (gnt_if_c) begin
            last_winner <= SRC_IF;
        end else if (gnt_d_c) begin
            last_winner <= SRC_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction fetches and data loads/stores onto one fixed-latency memory port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    arb_src_t         lat_src;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;
    logic             arb_en_c;
    logic             gnt_if_c;
    logic             gnt_d_c;
    logic             any_gnt_c;
    logic             win_we_c;

    // Grants are only possible in IDLE and are suppressed while reset is held.
    assign arb_en_c  = (state == IDLE) && rst_n;
    assign any_gnt_c = gnt_if_c | gnt_d_c;
    assign win_we_c  = gnt_d_c & d_we;
    assign if_gnt    = gnt_if_c;
    assign d_gnt     = gnt_d_c;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (arb_en_c),
        .req_if   (if_req),
        .req_d    (d_req),
        .gnt_if_c (gnt_if_c),
        .gnt_d_c  (gnt_d_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt_c) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and completion pulses are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            lat_src    <= SRC_D;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= FUNCT3_WORD;
            cnt        <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            mem_re    <= any_gnt_c & ~win_we_c;
            mem_we    <= win_we_c;
            if_rvalid <= (state_nxt == RESP) && (lat_src == SRC_IF);
            d_rvalid  <= (state_nxt == RESP) && (lat_src == SRC_D);

            if (any_gnt_c) begin
                lat_src    <= gnt_d_c ? SRC_D : SRC_IF;
                lat_we     <= win_we_c;
                mem_addr   <= gnt_d_c ? d_addr : if_addr;
                mem_funct3 <= gnt_d_c ? d_funct3 : FUNCT3_WORD;
                if (gnt_d_c) begin
                    mem_wdata <= d_wdata;
                end
            end

            if (state == ISSUE) begin
                cnt <= CNT_W'(READ_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            if ((state == WAIT) && (cnt == CNT_W'(1))) begin
                if (lat_src == SRC_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic against a cycle-level reference.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int RL  = 1;
    localparam int RL4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (READ_LAT=1)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [2:0]  d_funct3 = 3'b010;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;

    // second DUT (READ_LAT=4)
    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0, b_mem_rdata = '0;
    logic [2:0]  b_d_funct3 = 3'b010;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_re, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [2:0]  b_mem_funct3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_funct3(b_d_funct3),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
        .mem_funct3(b_mem_funct3), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory contents: explicit writes, otherwise an address-derived pattern
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_3C3C;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic [31:0] ref_mem [logic [31:0]];
    exp_t        if_q[$];
    exp_t        d_q[$];
    bit          gnt_log[$];
    bit          ref_last_d = 1'b1;
    int          ref_free = 0;
    int          ref_gnt_cyc = -100;
    logic [31:0] ref_d_last = '0;
    int          st_cyc = -100;
    bit          st_we;
    logic [31:0] st_addr, st_wdata;
    logic [2:0]  st_f3;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic ref_reset();
        if_q.delete();
        d_q.delete();
        ref_free    = 0;
        ref_gnt_cyc = -100;
        st_cyc      = -100;
        ref_last_d  = 1'b1;
        ref_d_last  = '0;
    endtask

    // ---------------- memory slave for main DUT ----------------
    logic [31:0] slv_mem [logic [31:0]];
    int          slv_rem = -1;
    logic [31:0] slv_addr = '0;

    always @(negedge clk) begin
        mem_rdata = 32'hBAD0_BAD0;
        if (!rst_n) begin
            slv_rem = -1;
        end else begin
            if (mem_we) slv_mem[mem_addr] = mem_wdata;
            if (mem_re) begin
                slv_rem  = RL;
                slv_addr = mem_addr;
            end else if (slv_rem > 0) begin
                slv_rem--;
                if (slv_rem == 0)
                    mem_rdata = slv_mem.exists(slv_addr) ? slv_mem[slv_addr] : dflt(slv_addr);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          e_if, e_d, exp_v;
    logic [31:0] e_addr;
    exp_t        e;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            e_if = 1'b0;
            e_d  = 1'b0;
            if (cyc >= ref_free && (if_req || d_req)) begin
                if (if_req && d_req) begin
                    e_if = ref_last_d;
                    e_d  = !ref_last_d;
                end else begin
                    e_if = if_req;
                    e_d  = d_req;
                end
            end
            chk1("if_gnt", if_gnt, e_if);
            chk1("d_gnt", d_gnt, e_d);
            chk1("gnt_onehot", if_gnt & d_gnt, 1'b0);
            chk1("busy", busy, (cyc > ref_gnt_cyc) && (cyc < ref_free));
            if (if_gnt || d_gnt) gnt_log.push_back(d_gnt);

            // strobes and address hold
            chk1("mem_re", mem_re, (cyc == st_cyc) && !st_we);
            chk1("mem_we", mem_we, (cyc == st_cyc) && st_we);
            if (cyc == st_cyc) begin
                chk32("mem_addr", mem_addr, st_addr);
                chk32("mem_funct3", 32'(mem_funct3), 32'(st_f3));
                if (st_we) chk32("mem_wdata", mem_wdata, st_wdata);
            end else if (!st_we && cyc > st_cyc && cyc <= st_cyc + RL) begin
                chk32("mem_addr_hold", mem_addr, st_addr);
            end

            // completions
            exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
            chk1("if_rvalid", if_rvalid, exp_v);
            if (exp_v) begin
                chk32("if_rdata", if_rdata, if_q[0].data);
                void'(if_q.pop_front());
            end
            exp_v = (d_q.size() > 0) && (d_q[0].due == cyc);
            chk1("d_rvalid", d_rvalid, exp_v);
            if (exp_v) begin
                chk32(d_q[0].we ? "d_rdata_store_hold" : "d_rdata", d_rdata, d_q[0].data);
                void'(d_q.pop_front());
            end

            // issue-time expectation
            if (e_if || e_d) begin
                e_addr = e_d ? d_addr : if_addr;
                e.we   = e_d && d_we;
                if (e.we) begin
                    ref_mem[e_addr] = d_wdata;
                    e.data = ref_d_last;
                    e.due  = cyc + 2;
                end else begin
                    e.data = ref_rd(e_addr);
                    e.due  = cyc + 2 + RL;
                    if (e_d) ref_d_last = e.data;
                end
                st_cyc      = cyc + 1;
                st_we       = e.we;
                st_addr     = e_addr;
                st_wdata    = d_wdata;
                st_f3       = e_d ? d_funct3 : 3'b010;
                ref_gnt_cyc = cyc;
                ref_free    = cyc + (e.we ? 3 : RL + 3);
                ref_last_d  = e_d;
                if (e_d) d_q.push_back(e);
                else     if_q.push_back(e);
            end
        end
    end

    // ---------------- requester agents ----------------
    task automatic fetch_req(input logic [31:0] a);
        bit got = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = if_gnt;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL if_gnt_timeout: no grant for addr %h", a);
        end
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        bit got = 1'b0;
        d_req    = 1'b1;
        d_we     = we;
        d_addr   = a;
        d_wdata  = wd;
        d_funct3 = f3;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = d_gnt;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL d_gnt_timeout: no grant for addr %h", a);
        end
        d_req    = 1'b0;
        d_we     = $urandom_range(0, 1);
        d_addr   = $urandom;
        d_wdata  = $urandom;
        d_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic apply_reset();
        #1 rst_n = 1'b0;
        ref_reset();
        #1;
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_funct3", 32'(mem_funct3), 32'h2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'(4 * $urandom_range(0, 15));
    endfunction

    // ---------------- READ_LAT=4 directed load ----------------
    task automatic lat4_load();
        bit got = 1'b0;
        b_d_req    = 1'b1;
        b_d_we     = 1'b0;
        b_d_addr   = 32'h300;
        b_d_funct3 = 3'b010;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = b_d_gnt;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        chk1("l4_gnt", got, 1'b1);
        @(posedge clk);
        #1;
        b_d_req  = 1'b0;
        b_d_addr = 32'hFFFF_FFF0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            b_mem_rdata = (k == 5) ? 32'h1234_ABCD : 32'hBAD0_0000 + 32'(k);
            if (k <= 5) chk32("l4_mem_addr_hold", b_mem_addr, 32'h300);
            chk1("l4_mem_re", b_mem_re, k == 1);
            chk1("l4_d_rvalid", b_d_rvalid, k == 6);
            chk1("l4_busy", b_busy, k <= 6);
            if (k == 6) chk32("l4_d_rdata", b_d_rdata, 32'h1234_ABCD);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        apply_reset();
        mon_en = 1'b1;

        // lone fetch
        ref_mem[32'h10] = 32'h0050_0093;
        slv_mem[32'h10] = 32'h0050_0093;
        fetch_req(32'h10);
        repeat (4) begin @(posedge clk); #1; end

        // load then store: store must leave d_rdata untouched
        data_req(1'b0, 32'h44, 32'h0, 3'b010);
        repeat (4) begin @(posedge clk); #1; end
        data_req(1'b1, 32'h200, 32'hDEAD_BEEF, 3'b000);
        repeat (3) begin @(posedge clk); #1; end
        data_req(1'b0, 32'h200, 32'h0, 3'b010);
        repeat (4) begin @(posedge clk); #1; end

        // simultaneous requests after reset: fetch, data, fetch
        apply_reset();
        gnt_log.delete();
        fork
            begin fetch_req(32'h20); fetch_req(32'h24); end
            begin data_req(1'b0, 32'h400, 32'h0, 3'b010); data_req(1'b1, 32'h404, 32'h55AA_55AA, 3'b010); end
        join
        repeat (6) begin @(posedge clk); #1; end
        chk32("tie_count", 32'(gnt_log.size()), 32'd4);
        chk1("tie_order0", gnt_log[0], 1'b0);
        chk1("tie_order1", gnt_log[1], 1'b1);
        chk1("tie_order2", gnt_log[2], 1'b0);

        // reset during WAIT, then a tie must go to fetch
        fetch_req(32'h80);
        @(posedge clk);
        #1;
        apply_reset();
        repeat (4) begin @(posedge clk); #1; end
        gnt_log.delete();
        fork
            fetch_req(32'h84);
            data_req(1'b0, 32'h88, 32'h0, 3'b010);
        join
        repeat (6) begin @(posedge clk); #1; end
        chk32("post_rst_count", 32'(gnt_log.size()), 32'd2);
        chk1("post_rst_first", gnt_log[0], 1'b0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] fa, da, dw;
            logic        dwe;
            logic [2:0]  df3;
            fa  = rand_addr();
            da  = rand_addr();
            dw  = $urandom;
            dwe = 1'($urandom_range(0, 1));
            df3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: fetch_req(fa);
                1: data_req(dwe, da, dw, df3);
                default: fork
                    fetch_req(fa);
                    data_req(dwe, da, dw, df3);
                join
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (8) begin @(posedge clk); #1; end

        lat4_load();
        repeat (2) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared instruction/data memory port of the multicycle RV32I core. It serializes instruction fetches and data loads/stores onto one memory port and runs a fixed-latency read/write FSM. Each requester gets an explicit grant and a completion pulse. It sits between the control unit/datapath and the memory module, which removes the fetch-versus-data address muxing from the core.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `READ_LAT`, 1: memory read latency in cycles, from the `mem_re` cycle to the cycle `mem_rdata` is valid. Legal range is 1..4.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request (read-only).
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted.
- `if_rvalid` out 1: fetch data valid (one-cycle pulse).
- `if_rdata` out DATA_W: fetched word.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_funct3` in 3: access size/sign.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: data access complete (one-cycle pulse). Load data is valid with it.
- `d_rdata` out DATA_W: load data.
- `mem_addr` out ADDR_W: memory address.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out DATA_W: memory write data.
- `mem_funct3` out 3: memory access size.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If exactly one req is high, that requester wins.
  - If both are high, the requester not granted last wins (round-robin).
  - The `last_winner` register resets to data, so fetch wins the first tie.
  - The winner's gnt is asserted combinationally in this cycle.
  - addr, we, wdata and funct3 are latched into internal registers. A fetch latches we=0 and funct3=3'b010.
  - Next state is ISSUE. With no req, the FSM stays in IDLE.
- **ISSUE**
  - `mem_addr`, `mem_wdata` and `mem_funct3` are driven from the latches.
  - Read: `mem_re`=1 for exactly this cycle, the wait counter is loaded with READ_LAT, and next state is WAIT.
  - Write: `mem_we`=1 for exactly this cycle, and next state is RESP.
- **WAIT**
  - The counter decrements each cycle. `mem_addr` is held stable.
  - In the cycle where the count is 1, `mem_rdata` is captured into the winner's rdata register and the next state is RESP.
- **RESP**
  - The winner's rvalid pulses for one cycle. Next state is IDLE.
  - Write: `d_rdata` is unchanged.
- Requesters may drop or change req, addr or wdata after gnt without effect on the transaction in flight.
- A req dropped before gnt has no effect.
- No request is accepted outside IDLE. Requests must be held until gnt.
- `if_rdata` and `d_rdata` are registers and hold their value until the next read completion for that requester.
- `busy` = (state != IDLE).

## Timing
- **Reset values:** state IDLE; all gnt, rvalid, `mem_re`, `mem_we` and `busy` at 0; `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` at 0; `mem_funct3` at 3'b010; `last_winner` = data.
- **Read accepted in cycle T:** gnt in T, `mem_re` in T+1, `mem_rdata` sampled at the end of T+1+READ_LAT, rvalid in T+2+READ_LAT.
  - Read occupancy is READ_LAT+3 cycles.
- **Write accepted in cycle T:** gnt in T, `mem_we` in T+1, `d_rvalid` in T+2.
  - Write occupancy is 3 cycles.
- **Earliest next gnt:** the cycle after RESP, not during RESP.
- **Simultaneous requests:** only one gnt is ever high in a cycle, and gnt is never high outside IDLE.
- **Reset mid-operation:**
  - The FSM returns to IDLE immediately and strobes deassert.
  - The in-flight transaction is discarded and no rvalid is issued.
  - `last_winner` returns to data.
- **Width rule:** the counter is 3 bits and counts READ_LAT (≤4) down to 1. No arithmetic is performed on addresses.

## Structure
- **Shared package `mem_arb_pkg`:**
  - `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `arb_src_t` enum (SRC_IF, SRC_D).
  - Constant `FUNCT3_WORD` = 3'b010.
- **Sub-module `rr_arb2`:** a natural split. It is the combinational 2-way round-robin pick plus the `last_winner` flop, updated on grant. The FSM and datapath latches stay in the top module.

## Test plan
- **Lone fetch:** `if_req`=1 with `if_addr`=0x10, memory returns 0x00500093, READ_LAT=1. Expected: `if_gnt` at T, `mem_re`/`mem_addr`=0x10 at T+1, `if_rvalid` with 0x00500093 at T+3, `busy` low at T+4.
- **Store:**
  - Stimulus: `d_req` with `d_we`=1, addr 0x200, wdata 0xDEADBEEF, funct3 3'b000.
  - Expected: `mem_we`=1 for one cycle with those values and `mem_funct3`=000, then `d_rvalid` at T+2 with `d_rdata` unchanged.
- **Simultaneous requests:**
  - Stimulus: `if_req` and `d_req` both held high across three transactions after reset.
  - Expected: grant order fetch, data, fetch; never two gnt in one cycle.
- **READ_LAT=4 load:**
  - Stimulus: data load from 0x300.
  - Expected: `mem_addr` stable for 5 cycles, and `d_rvalid` exactly 6 cycles after `d_gnt`.
- **Mid-read reset:**
  - Stimulus: assert `rst_n`=0 during WAIT.
  - Expected: all outputs at reset values within the same cycle, no rvalid afterwards, and the next tie grants fetch.
